// File: rtl/round_ctrl_np.sv
// round_ctrl_np: round-robin turn controller with per-player HP, answer timer and last-survivor winner
module round_ctrl_np #(
  parameter int NP = 2,
  parameter int HPW = 2,
  parameter int QW = 4,
  parameter int TOUT = 1000,
  localparam int PW = NP > 2 ? $clog2(NP) : 1,
  localparam int TW = $clog2(TOUT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [HPW-1:0]    i_hp_init,
  input  logic              i_start,
  input  logic              i_que_ack,
  input  logic              i_ans_valid,
  input  logic [PW-1:0]     i_ans_player,
  input  logic              i_ans_ok,
  output logic [2:0]        o_state,
  output logic [PW-1:0]     o_cur_player,
  output logic [QW-1:0]     o_q_num,
  output logic [NP*HPW-1:0] o_hp_out,
  output logic [TW-1:0]     o_timer,
  output logic              o_hit,
  output logic [PW-1:0]     o_winner,
  output logic              o_game_over
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ANSWER, S_JUDGE, S_NEXT, S_OVER} state_t;
  state_t r_state, w_state;
  logic [PW-1:0] r_cur, w_cur, r_win, w_win, w_nxt, w_low;
  logic [QW-1:0] r_q, w_q;
  logic [NP*HPW-1:0] r_hp, w_hp;
  logic [TW-1:0] r_timer, w_timer;
  logic r_miss, w_miss, w_take, w_nxt_found, w_low_found;
  logic [HPW-1:0] w_hp0, w_cur_hp;
  logic [3:0] w_alive;
  assign w_cur_hp = r_hp[int'(r_cur)*HPW +: HPW];
  assign w_hp0 = i_hp_init == '0 ? HPW'(1) : i_hp_init;
  assign w_take = r_state == S_ANSWER && i_ans_valid && i_ans_player == r_cur;
  // survivor count, lowest survivor, and next survivor after the current player (wrapping)
  always_comb begin
    w_alive = '0;
    w_low = '0;
    w_low_found = 1'b0;
    w_nxt = r_cur;
    w_nxt_found = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (r_hp[i*HPW +: HPW] != '0) begin
        w_alive = w_alive + 4'd1;
        if (!w_low_found) begin
          w_low = PW'(i);
          w_low_found = 1'b1;
        end
      end
    end
    for (int k = 1; k <= NP; k++) begin
      if (!w_nxt_found && r_hp[((int'(r_cur) + k) % NP)*HPW +: HPW] != '0) begin
        w_nxt = PW'((int'(r_cur) + k) % NP);
        w_nxt_found = 1'b1;
      end
    end
  end
  always_comb begin
    w_state = r_state;
    w_cur = r_cur;
    w_win = r_win;
    w_q = r_q;
    w_hp = r_hp;
    w_timer = r_timer;
    w_miss = r_miss;
    case (r_state)
      S_IDLE, S_OVER: if (i_start) begin
        w_state = S_LOAD;
        w_hp = {NP{w_hp0}};
        w_cur = '0;
        w_q = '0;
        w_win = '0;
        w_miss = 1'b0;
      end
      S_LOAD: if (i_que_ack) begin
        w_state = S_ANSWER;
        w_timer = TW'(TOUT);
      end
      S_ANSWER: begin
        w_timer = (w_take || r_timer == TW'(1)) ? '0 : r_timer - TW'(1);
        w_state = (w_take || r_timer == TW'(1)) ? S_JUDGE : S_ANSWER;
        w_miss = w_take ? ~i_ans_ok : (r_timer == TW'(1) ? 1'b1 : r_miss);
      end
      S_JUDGE: begin
        w_state = S_NEXT;
        if (r_miss && w_cur_hp != '0) w_hp[int'(r_cur)*HPW +: HPW] = w_cur_hp - HPW'(1);
      end
      S_NEXT: begin
        w_cur = w_nxt;
        w_state = w_alive <= 4'd1 ? S_OVER : S_LOAD;
        w_win = w_alive <= 4'd1 ? (w_low_found ? w_low : r_cur) : r_win;
        w_q = w_alive <= 4'd1 ? r_q : r_q + QW'(1);
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cur <= '0;
      r_win <= '0;
      r_q <= '0;
      r_hp <= '0;
      r_timer <= '0;
      r_miss <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cur <= w_cur;
      r_win <= w_win;
      r_q <= w_q;
      r_hp <= w_hp;
      r_timer <= w_timer;
      r_miss <= w_miss;
    end
  end
  assign o_state = r_state;
  assign o_cur_player = r_cur;
  assign o_q_num = r_q;
  assign o_hp_out = r_hp;
  assign o_timer = r_timer;
  assign o_hit = r_state == S_JUDGE && r_miss && w_cur_hp != '0;
  assign o_winner = r_win;
  assign o_game_over = r_state == S_OVER;
endmodule

// File: tb/tb_round_ctrl_np.sv
// tb_round_ctrl_np: directed scenario tests on a 2-player (QW=2) and a 3-player controller
module tb_round_ctrl_np;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, que_ack = 1'b0, ans_valid = 1'b0, ans_ok = 1'b0;
  logic [1:0] hp_init = 2'd0, ans_player = 2'd0;
  logic [2:0] st2, st3;
  logic cur2, win2, hit2, go2, hit3, go3;
  logic [1:0] cur3, win3, q2;
  logic [3:0] q3, tm2, tm3;
  logic [3:0] hp2;
  logic [5:0] hp3;
  int total = 0, bad = 0, hits = 0, n;
  logic [1:0] exp_q [5];
  always #5 clk = ~clk;
  round_ctrl_np #(.NP(2), .HPW(2), .QW(2), .TOUT(8)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_hp_init(hp_init), .i_start(start), .i_que_ack(que_ack),
    .i_ans_valid(ans_valid), .i_ans_player(ans_player[0]), .i_ans_ok(ans_ok),
    .o_state(st2), .o_cur_player(cur2), .o_q_num(q2), .o_hp_out(hp2), .o_timer(tm2),
    .o_hit(hit2), .o_winner(win2), .o_game_over(go2));
  round_ctrl_np #(.NP(3), .HPW(2), .QW(4), .TOUT(8)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_hp_init(hp_init), .i_start(start), .i_que_ack(que_ack),
    .i_ans_valid(ans_valid), .i_ans_player(ans_player), .i_ans_ok(ans_ok),
    .o_state(st3), .o_cur_player(cur3), .o_q_num(q3), .o_hp_out(hp3), .o_timer(tm3),
    .o_hit(hit3), .o_winner(win3), .o_game_over(go3));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic begin_game(input logic [1:0] hp);
    hp_init = hp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic round(input logic [1:0] p, input logic ok);
    que_ack = 1'b1;
    step();
    que_ack = 1'b0;
    ans_valid = 1'b1;
    ans_player = p;
    ans_ok = ok;
    step();
    ans_valid = 1'b0;
    if (hit2) hits++;
    step();
    step();
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (st2 !== 3'd0 || st3 !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0", st2, st3); end
    total++; if (hp2 !== 4'd0 || tm2 !== 4'd0 || go2 !== 1'b0 || q2 !== 2'd0) begin bad++; $display("FAIL reset_outs hp=%h tm=%0d go=%b q=%0d exp=0", hp2, tm2, go2, q2); end
  endtask
  task automatic test_basic_game();
    do_reset();
    hits = 0;
    begin_game(2'd2);
    total++; if (st2 !== 3'd1 || hp2 !== 4'b1010) begin bad++; $display("FAIL t1_start st=%0d hp=%b exp st=1 hp=1010", st2, hp2); end
    round(2'd0, 1'b0);
    total++; if (hp2 !== 4'b1001 || cur2 !== 1'b1 || q2 !== 2'd1) begin bad++; $display("FAIL t1_r1 hp=%b cur=%0d q=%0d exp hp=1001 cur=1 q=1", hp2, cur2, q2); end
    round(2'd1, 1'b1);
    total++; if (hp2 !== 4'b1001 || cur2 !== 1'b0 || q2 !== 2'd2) begin bad++; $display("FAIL t1_r2 hp=%b cur=%0d q=%0d exp hp=1001 cur=0 q=2", hp2, cur2, q2); end
    round(2'd0, 1'b0);
    total++; if (go2 !== 1'b1 || st2 !== 3'd5 || win2 !== 1'b1 || q2 !== 2'd2 || hp2 !== 4'b1000) begin bad++; $display("FAIL t1_over go=%b st=%0d win=%0d q=%0d hp=%b exp go=1 st=5 win=1 q=2 hp=1000", go2, st2, win2, q2, hp2); end
    total++; if (hits !== 2) begin bad++; $display("FAIL t1_hits got=%0d exp=2", hits); end
  endtask
  task automatic test_timeout();
    do_reset();
    begin_game(2'd2);
    que_ack = 1'b1;
    step();
    que_ack = 1'b0;
    total++; if (st2 !== 3'd2 || tm2 !== 4'd8) begin bad++; $display("FAIL t2_entry st=%0d tm=%0d exp st=2 tm=8", st2, tm2); end
    n = 0;
    while (st2 == 3'd2 && n < 20) begin step(); n++; end
    total++; if (n !== 8 || st2 !== 3'd3 || hit2 !== 1'b1 || tm2 !== 4'd0) begin bad++; $display("FAIL t2_timeout cycles=%0d st=%0d hit=%b tm=%0d exp 8/3/1/0", n, st2, hit2, tm2); end
    step();
    total++; if (hp2 !== 4'b1001) begin bad++; $display("FAIL t2_hp got=%b exp=1001", hp2); end
    do_reset();
    begin_game(2'd2);
    que_ack = 1'b1;
    step();
    que_ack = 1'b0;
    for (int i = 0; i < 7; i++) step();
    total++; if (st2 !== 3'd2 || tm2 !== 4'd1) begin bad++; $display("FAIL t2_last st=%0d tm=%0d exp st=2 tm=1", st2, tm2); end
    ans_valid = 1'b1;
    ans_player = 2'd0;
    ans_ok = 1'b1;
    step();
    ans_valid = 1'b0;
    total++; if (st2 !== 3'd3 || hit2 !== 1'b0) begin bad++; $display("FAIL t2_race st=%0d hit=%b exp st=3 hit=0", st2, hit2); end
    step();
    total++; if (hp2 !== 4'b1010) begin bad++; $display("FAIL t2_race_hp got=%b exp=1010", hp2); end
  endtask
  task automatic test_skip_dead();
    do_reset();
    begin_game(2'd1);
    round(2'd0, 1'b1);
    round(2'd1, 1'b0);
    total++; if (hp3 !== 6'b010001 || cur3 !== 2'd2 || st3 !== 3'd1) begin bad++; $display("FAIL t3_dead hp=%b cur=%0d st=%0d exp hp=010001 cur=2 st=1", hp3, cur3, st3); end
    que_ack = 1'b1;
    step();
    que_ack = 1'b0;
    ans_valid = 1'b1;
    ans_player = 2'd1;
    ans_ok = 1'b0;
    step();
    ans_valid = 1'b0;
    total++; if (st3 !== 3'd2 || hit3 !== 1'b0) begin bad++; $display("FAIL t3_ignore st=%0d hit=%b exp st=2 hit=0", st3, hit3); end
    ans_valid = 1'b1;
    ans_player = 2'd2;
    ans_ok = 1'b1;
    step();
    ans_valid = 1'b0;
    step();
    step();
    total++; if (cur3 !== 2'd0) begin bad++; $display("FAIL t3_order_a cur=%0d exp=0", cur3); end
    round(2'd0, 1'b1);
    total++; if (cur3 !== 2'd2) begin bad++; $display("FAIL t3_order_b cur=%0d exp=2", cur3); end
    round(2'd2, 1'b1);
    total++; if (cur3 !== 2'd0 || go3 !== 1'b0 || hp3 !== 6'b010001) begin bad++; $display("FAIL t3_order_c cur=%0d go=%b hp=%b exp cur=0 go=0 hp=010001", cur3, go3, hp3); end
  endtask
  task automatic test_hp_zero_and_restart();
    do_reset();
    begin_game(2'd0);
    total++; if (hp2 !== 4'b0101) begin bad++; $display("FAIL t4_hp got=%b exp=0101", hp2); end
    round(2'd0, 1'b0);
    total++; if (go2 !== 1'b1 || win2 !== 1'b1 || hp2 !== 4'b0100) begin bad++; $display("FAIL t4_over go=%b win=%0d hp=%b exp go=1 win=1 hp=0100", go2, win2, hp2); end
    begin_game(2'd3);
    total++; if (st2 !== 3'd1 || hp2 !== 4'b1111 || go2 !== 1'b0 || cur2 !== 1'b0 || q2 !== 2'd0 || win2 !== 1'b0) begin bad++; $display("FAIL t6_restart st=%0d hp=%b go=%b cur=%0d q=%0d win=%0d exp 1/1111/0/0/0/0", st2, hp2, go2, cur2, q2, win2); end
  endtask
  task automatic test_wrap_and_abort();
    do_reset();
    begin_game(2'd2);
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      round(2'(i % 2), 1'b1);
      total++; if (q2 !== exp_q[i]) begin bad++; $display("FAIL t5_q%0d got=%0d exp=%0d", i, q2, exp_q[i]); end
    end
    que_ack = 1'b1;
    step();
    que_ack = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (st2 !== 3'd2 || q2 !== 2'd1 || tm2 !== 4'd7) begin bad++; $display("FAIL t5_start_ignored st=%0d q=%0d tm=%0d exp 2/1/7", st2, q2, tm2); end
    #2 rst = 1'b1;
    #1;
    total++; if (st2 !== 3'd0 || hp2 !== 4'd0 || tm2 !== 4'd0 || q2 !== 2'd0 || cur2 !== 1'b0 || go2 !== 1'b0) begin bad++; $display("FAIL t5_abort st=%0d hp=%b tm=%0d q=%0d cur=%0d go=%b exp all 0", st2, hp2, tm2, q2, cur2, go2); end
    step();
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic_game();
    test_timeout();
    test_skip_dead();
    test_hp_zero_and_restart();
    test_wrap_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
